// File: rtl/mmio_uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mmio_uart_pkg : register map, status bits, funct3 codes, FSM enum |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package mmio_uart_pkg;

  localparam logic [3:0] TXDATA_OFF = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] BAUD_OFF   = 4'h8;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with full/empty/count outputs       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             w_do_pop;
  logic             w_do_push;

  // A pop frees a slot in the same cycle, so a push while full is still taken.
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (w_do_push && !w_do_pop)      count_q <= count_q + 1'b1;
      else if (!w_do_push && w_do_pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mmio_uart_tx : memory-mapped 8N1 UART transmitter on the data bus |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write_en,
  input  logic [2:0]  s_type,
  input  logic [2:0]  l_type,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        hit,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e    state_q;
  logic [15:0]  baud_q, baud_d, div_q, cnt_q;
  logic [7:0]   shift_q;
  logic [2:0]   bit_q;
  logic         tx_q, ovf_q;

  logic [3:0]   w_off;
  logic         w_push, w_pop, w_status_wr, w_baud_wr, w_bit_end;
  logic [7:0]   w_fifo_rdata;
  logic         w_full, w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]  w_raw, w_fmt;
  logic         w_unused;

  assign w_unused    = ^mem_wdata[31:16];
  assign w_off       = mem_addr[3:0];
  assign hit         = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_push      = mem_write_en & hit & (w_off == TXDATA_OFF);
  assign w_status_wr = mem_write_en & hit & (w_off == STATUS_OFF);
  assign w_baud_wr   = mem_write_en & hit & (w_off == BAUD_OFF);
  assign w_bit_end   = (cnt_q == div_q - 16'd1);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .wdata_i (mem_wdata[7:0]),
    .pop_i   (w_pop),
    .rdata_o (w_fifo_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // Pops happen when idle, or at the last cycle of a stop bit for gapless frames.
  always_comb begin
    w_pop = 1'b0;
    if (!w_empty) begin
      if (state_q == TX_IDLE) w_pop = 1'b1;
      else if (state_q == TX_STOP && w_bit_end) w_pop = 1'b1;
    end
  end

  always_comb begin
    baud_d = baud_q;
    if (s_type == F3_SB) baud_d[7:0] = mem_wdata[7:0];
    else                 baud_d      = mem_wdata[15:0];
    if (baud_d == 16'd0) baud_d = 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q <= DEFAULT_DIV;
      ovf_q  <= 1'b0;
    end else begin
      if (w_baud_wr) baud_q <= baud_d;
      if (w_push && w_full && !w_pop) ovf_q <= 1'b1;
      else if (w_status_wr && mem_wdata[ST_OVF]) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      div_q   <= DEFAULT_DIV;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (w_pop) begin
            shift_q <= w_fifo_rdata;
            div_q   <= baud_q;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (w_bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= TX_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            cnt_q <= '0;
            if (w_pop) begin
              shift_q <= w_fifo_rdata;
              div_q   <= baud_q;
              tx_q    <= 1'b0;
              state_q <= TX_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= TX_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_raw = '0;
    if (w_off == STATUS_OFF) begin
      w_raw[ST_BUSY]          = (state_q != TX_IDLE);
      w_raw[ST_FULL]          = w_full;
      w_raw[ST_EMPTY]         = w_empty;
      w_raw[ST_OVF]           = ovf_q;
      w_raw[ST_CNT_LSB +: 3]  = 3'(w_count);
    end else if (w_off == BAUD_OFF) begin
      w_raw[15:0] = baud_q;
    end
    case (l_type)
      F3_LB:   w_fmt = {{24{w_raw[7]}}, w_raw[7:0]};
      F3_LH:   w_fmt = {{16{w_raw[15]}}, w_raw[15:0]};
      F3_LBU:  w_fmt = {24'd0, w_raw[7:0]};
      F3_LHU:  w_fmt = {16'd0, w_raw[15:0]};
      default: w_fmt = w_raw;
    endcase
  end

  assign mem_rdata = hit ? w_fmt : 32'd0;
  assign tx        = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mmio_uart_tx : vector table, directed frames and random traffic|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          DEPTH  = 4;
  localparam logic [15:0] DEFDIV = 16'd868;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write_en;
  logic [2:0]  s_type, l_type;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        hit, tx;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEFDIV)) dut (
    .clk(clk), .reset(reset), .mem_write_en(mem_write_en), .s_type(s_type),
    .l_type(l_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .hit(hit), .tx(tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a byte queue plus the single frame currently on the line.
  logic [7:0] m_q[$];
  bit         m_ovf;
  int         m_baud, m_free, cyc;
  bit         m_valid;
  int         m_start, m_div;
  logic [7:0] m_byte;

  typedef struct {
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          exp_hit;
  } vec_t;
  vec_t vecs[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic bit tb_hit(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic bit m_active();
    return m_valid && ((cyc - m_start) < 10 * m_div);
  endfunction

  function automatic logic m_tx();
    int p;
    if (!m_active()) return 1'b1;
    p = (cyc - m_start) / m_div;
    if (p == 0) return 1'b0;
    if (p <= 8) return m_byte[p-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    int n;
    n = m_q.size();
    return {25'd0, 3'(n), m_ovf, (n == 0), (n == DEPTH), m_active()};
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [2:0] lt);
    logic [31:0] raw;
    if (!tb_hit(a)) return 32'd0;
    raw = 32'd0;
    if (a[3:0] == 4'h4) raw = m_status();
    else if (a[3:0] == 4'h8) raw = 32'(m_baud);
    case (lt)
      3'b000:  return 32'($signed(raw[7:0]));
      3'b001:  return 32'($signed(raw[15:0]));
      3'b100:  return {24'd0, raw[7:0]};
      3'b101:  return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  task automatic model_edge();
    bit pop;
    cyc++;
    if (reset) begin
      m_q.delete();
      m_ovf = 0; m_baud = int'(DEFDIV); m_free = 0; m_valid = 0;
      return;
    end
    pop = (m_q.size() != 0) && (cyc >= m_free);
    if (pop) begin
      m_byte  = m_q.pop_front();
      m_valid = 1; m_start = cyc; m_div = m_baud;
      m_free  = cyc + 10 * m_baud;
    end
    if (mem_write_en && tb_hit(mem_addr)) begin
      if (mem_addr[3:0] == 4'h0) begin
        if (m_q.size() >= DEPTH) m_ovf = 1;
        else m_q.push_back(mem_wdata[7:0]);
      end else if (mem_addr[3:0] == 4'h4) begin
        if (mem_wdata[3]) m_ovf = 0;
      end else if (mem_addr[3:0] == 4'h8) begin
        if (s_type == 3'b000) m_baud = (m_baud & 32'hFF00) | int'(mem_wdata[7:0]);
        else m_baud = int'(mem_wdata[15:0]);
        if (m_baud == 0) m_baud = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("tx_line", {31'd0, tx}, {31'd0, m_tx()});
  endtask

  task automatic store(input logic [2:0] st, input logic [31:0] a, input logic [31:0] d);
    mem_write_en = 1'b1; s_type = st; mem_addr = a; mem_wdata = d;
    tick();
    mem_write_en = 1'b0;
  endtask

  task automatic load_const(input string nm, input logic [2:0] lt, input logic [31:0] a,
                            input logic [31:0] exp);
    mem_write_en = 1'b0; l_type = lt; mem_addr = a;
    #1;
    chk(nm, mem_rdata, exp);
  endtask

  task automatic load_model(input string nm, input logic [2:0] lt, input logic [31:0] a);
    mem_write_en = 1'b0; l_type = lt; mem_addr = a;
    #1;
    chk(nm, mem_rdata, m_read(a, lt));
    chk({nm, "_hit"}, {31'd0, hit}, {31'd0, tb_hit(a)});
  endtask

  initial begin
    logic [7:0]  c;
    logic [31:0] ra;
    logic [2:0]  rl;
    int          r, p;
    logic        eb;

    reset = 1'b1; mem_write_en = 1'b0; s_type = 3'b010; l_type = 3'b010;
    mem_addr = BASE; mem_wdata = 32'd0; cyc = 0;
    tick(); tick();
    reset = 1'b0;

    chk("reset_tx", {31'd0, tx}, 32'd1);
    load_const("reset_status", 3'b010, BASE + 32'h4, 32'h4);
    load_const("reset_baud", 3'b010, BASE + 32'h8, 32'h364);
    chk("reset_hit", {31'd0, hit}, 32'd1);
    tick();

    vecs[0]  = '{1'b1, 3'b010, BASE + 32'h8,  32'h0000_0000, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 3'b010, BASE + 32'h8,  32'h0, 32'h0000_0001, 1'b1};
    vecs[2]  = '{1'b1, 3'b001, BASE + 32'h8,  32'h0000_FFFF, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 3'b001, BASE + 32'h8,  32'h0, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{1'b0, 3'b101, BASE + 32'h8,  32'h0, 32'h0000_FFFF, 1'b1};
    vecs[5]  = '{1'b1, 3'b000, BASE + 32'h8,  32'h1234_5600, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 3'b010, BASE + 32'h8,  32'h0, 32'h0000_FF00, 1'b1};
    vecs[7]  = '{1'b0, 3'b000, BASE + 32'h8,  32'h0, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 3'b000, BASE + 32'h8,  32'h0000_0080, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 3'b000, BASE + 32'h8,  32'h0, 32'hFFFF_FF80, 1'b1};
    vecs[10] = '{1'b0, 3'b100, BASE + 32'h8,  32'h0, 32'h0000_0080, 1'b1};
    vecs[11] = '{1'b1, 3'b010, BASE + 32'hC,  32'h0000_DEAD, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 3'b010, BASE + 32'hC,  32'h0, 32'h0, 1'b1};
    vecs[13] = '{1'b0, 3'b010, BASE + 32'h10, 32'h0, 32'h0, 1'b0};
    vecs[14] = '{1'b1, 3'b010, BASE + 32'h10, 32'h0000_0077, 32'h0, 1'b0};
    vecs[15] = '{1'b1, 3'b010, BASE + 32'h2,  32'h0000_0099, 32'h0, 1'b0};
    vecs[16] = '{1'b0, 3'b010, BASE + 32'h4,  32'h0, 32'h0000_0004, 1'b1};
    vecs[17] = '{1'b0, 3'b010, BASE + 32'h0,  32'h0, 32'h0, 1'b1};
    vecs[18] = '{1'b0, 3'b010, BASE + 32'h8,  32'h0, 32'h0000_FF80, 1'b1};
    vecs[19] = '{1'b1, 3'b010, BASE + 32'h8,  32'h1234_0004, 32'h0, 1'b0};

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        store(vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      end else begin
        load_const($sformatf("vec%0d_rdata", i), vecs[i].f3, vecs[i].addr, vecs[i].exp);
        chk($sformatf("vec%0d_hit", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
        tick();
      end
    end

    // Basic frame at div 4: start bit one edge after the store, then LSB first.
    c = 8'h55;
    store(3'b000, BASE, 32'h0000_0055);
    chk("frame_pre", {31'd0, tx}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      tick();
      p = i / 4;
      if (p == 0) eb = 1'b0;
      else if (p <= 8) eb = c[p-1];
      else eb = 1'b1;
      chk($sformatf("frame_bit%0d", i), {31'd0, tx}, {31'd0, eb});
      if (i == 20) load_const("frame_busy", 3'b010, BASE + 32'h4, 32'h5);
    end
    tick();
    load_const("frame_done_status", 3'b010, BASE + 32'h4, 32'h4);
    tick();

    // Back-to-back at div 2 with one byte too many.
    store(3'b010, BASE + 32'h8, 32'd2);
    store(3'b010, BASE, 32'h11);
    store(3'b010, BASE, 32'h22);
    store(3'b010, BASE, 32'h33);
    store(3'b010, BASE, 32'h44);
    store(3'b010, BASE, 32'h55);
    store(3'b010, BASE, 32'h66);
    load_const("b2b_status", 3'b010, BASE + 32'h4, 32'h4B);
    load_model("b2b_status_m", 3'b010, BASE + 32'h4);
    repeat (5) tick();
    store(3'b010, BASE + 32'h4, 32'h8);
    load_const("ovf_clear", 3'b010, BASE + 32'h4, 32'h43);
    repeat (110) tick();
    load_const("b2b_done", 3'b010, BASE + 32'h4, 32'h4);

    // Divisor change mid-frame must not stretch the frame in flight.
    store(3'b010, BASE + 32'h8, 32'd3);
    store(3'b000, BASE, 32'hA5);
    repeat (5) tick();
    store(3'b001, BASE + 32'h8, 32'd5);
    repeat (40) tick();
    store(3'b000, BASE, 32'h3C);
    repeat (55) tick();
    load_model("div_change_status", 3'b010, BASE + 32'h4);

    // Random traffic against the model.
    store(3'b010, BASE + 32'h8, 32'd1);
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        store(3'($urandom_range(0, 2)), BASE, $urandom);
      end else if (r == 3) begin
        store(3'($urandom_range(0, 2)), BASE + 32'h8, 32'($urandom_range(0, 3)));
      end else if (r == 4) begin
        store(3'b010, BASE + 32'h4, $urandom);
      end else begin
        case ($urandom_range(0, 5))
          0: ra = BASE;
          1: ra = BASE + 32'h4;
          2: ra = BASE + 32'h8;
          3: ra = BASE + 32'hC;
          4: ra = BASE + 32'h2;
          default: ra = BASE + 32'h10;
        endcase
        case ($urandom_range(0, 4))
          0: rl = 3'b000;
          1: rl = 3'b001;
          2: rl = 3'b010;
          3: rl = 3'b100;
          default: rl = 3'b101;
        endcase
        load_model("rand_read", rl, ra);
        tick();
      end
    end

    // Reset in the middle of a data bit with a second byte still queued.
    store(3'b010, BASE + 32'h8, 32'd4);
    repeat (40) tick();
    store(3'b000, BASE, 32'hF0);
    store(3'b000, BASE, 32'h0F);
    repeat (12) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    load_const("rst_status", 3'b010, BASE + 32'h4, 32'h4);
    load_const("rst_baud", 3'b010, BASE + 32'h8, 32'h364);
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("rst_idle", {31'd0, tx}, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
